// File: rtl/iter_shift_unit_if.sv
// Purpose: request/response bundle for the iterative shifter (operands in, status and result out).
// Latency: none (wiring only).
// Backpressure: none; the master must only expect a start to take effect while busy and done are low.
interface iter_shift_unit_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [1:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   input_a;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   shift_result;

    // Requester side: drives the operation, observes status and result.
    modport master (
        output start, op, shamt, input_a,
        input  busy, done, shift_result
    );

    // Shifter side.
    modport slave (
        input  start, op, shamt, input_a,
        output busy, done, shift_result
    );
endinterface

// File: rtl/iter_shift_unit.sv
// Purpose: one-bit-per-cycle shifter (SLL/SRL/SRA; op=11 is ROTR with ITER_SHIFT_ROTATE_EN, else SRL).
// Latency: done is high in the cycle after edge T0+shamt, where T0 is the edge that accepts start.
// Backpressure: start is sampled only in IDLE; inputs are ignored while busy or done.
module iter_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    iter_shift_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   work;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   work_nxt;

    // Single-step shift of the working register according to the latched op.
    always_comb begin
        work_nxt = work;
        case (op_q)
            2'b00:   work_nxt = {work[WIDTH-2:0], 1'b0};
            2'b01:   work_nxt = {1'b0, work[WIDTH-1:1]};
            2'b10:   work_nxt = {work[WIDTH-1], work[WIDTH-1:1]};
`ifdef ITER_SHIFT_ROTATE_EN
            2'b11:   work_nxt = {work[0], work[WIDTH-1:1]};
`else
            // Without the rotate option op=11 is a plain logical right shift.
            2'b11:   work_nxt = {1'b0, work[WIDTH-1:1]};
`endif
            default: work_nxt = work;
        endcase
    end

    // Control FSM; busy/done/shift_result are registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            cnt              <= '0;
            work             <= '0;
            op_q             <= 2'b00;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.shift_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        work <= bus.input_a;
                        op_q <= bus.op;
                        cnt  <= bus.shamt;
                        if (bus.shamt == '0) begin
                            // Nothing to shift: publish the operand directly.
                            state            <= DONE;
                            bus.done         <= 1'b1;
                            bus.shift_result <= bus.input_a;
                        end else begin
                            state    <= SHIFT;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    work <= work_nxt;
                    cnt  <= cnt - 1'b1;
                    if (cnt == SHAMT_W'(1)) begin
                        // Last step: result is the freshly shifted value, not the stale register.
                        state            <= DONE;
                        bus.busy         <= 1'b0;
                        bus.done         <= 1'b1;
                        bus.shift_result <= work_nxt;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_shift_unit.sv
module tb_iter_shift_unit;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] exp_prev = 32'h0;

    iter_shift_unit_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    iter_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference: whole shift computed in one step from the operation definition.
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input int s, input logic [31:0] a);
        logic signed [31:0] sa;
        logic [63:0]        d;
        sa = a;
        d  = {a, a} >> s;
        case (o)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b10:   return sa >>> s;
`ifdef ITER_SHIFT_ROTATE_EN
            default: return d[31:0];
`else
            default: return a >> s;
`endif
        endcase
    endfunction

    // Issue one operation and observe it until done (bounded). Optionally scramble inputs mid-op.
    task automatic do_op(input logic [1:0] o, input logic [4:0] s, input logic [31:0] a, input bit noisy,
                         output int busy_cnt, output int lat, output int both, output int held_bad,
                         output logic [31:0] res, output logic done_after);
        busy_cnt = 0; both = 0; held_bad = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.shamt = s; bus.input_a = a;
        @(negedge clk);
        bus.start = 1'b0;
        if (noisy) begin
            bus.start = 1'($urandom); bus.op = 2'($urandom); bus.shamt = 5'($urandom); bus.input_a = $urandom;
        end
        lat = 1;
        while (bus.done !== 1'b1 && lat <= 100) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.shift_result !== exp_prev) held_bad++;
            @(negedge clk);
            if (noisy) begin
                bus.start = 1'($urandom); bus.op = 2'($urandom); bus.shamt = 5'($urandom); bus.input_a = $urandom;
            end
            lat++;
        end
        if (bus.busy === 1'b1) both++;
        res = bus.shift_result;
        bus.start = 1'b0;
        @(negedge clk);
        done_after = bus.done;
    endtask

    task automatic test_reset;
        bus.start = 1'b0; bus.op = 2'b00; bus.shamt = 5'd0; bus.input_a = 32'h0;
        reset_n = 1'b0;
        #12;
        n_cmp++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_err++; $display("FAIL reset_status: busy,done=%b required 00", {bus.busy, bus.done});
        end
        n_cmp++;
        if (bus.shift_result !== 32'h0) begin
            n_err++; $display("FAIL reset_result: got %h required 00000000", bus.shift_result);
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_prev = 32'h0;
    endtask

    // Checks one completed operation against the model and the timing rules.
    task automatic run_and_check(input string nm, input logic [1:0] o, input logic [4:0] s,
                                 input logic [31:0] a, input bit noisy);
        int bc, lat, both, hb;
        logic [31:0] res, exp;
        logic da;
        exp = ref_shift(o, int'(s), a);
        do_op(o, s, a, noisy, bc, lat, both, hb, res, da);
        n_cmp++;
        if (res !== exp) begin
            n_err++; $display("FAIL %s result: op=%0d shamt=%0d a=%h got %h required %h", nm, o, s, a, res, exp);
        end
        n_cmp++;
        if (lat != int'(s) + 1) begin
            n_err++; $display("FAIL %s latency: got %0d required %0d", nm, lat, int'(s) + 1);
        end
        n_cmp++;
        if (bc != int'(s)) begin
            n_err++; $display("FAIL %s busy_cycles: got %0d required %0d", nm, bc, int'(s));
        end
        n_cmp++;
        if (both != 0 || hb != 0) begin
            n_err++; $display("FAIL %s overlap/hold: busy&done=%0d unheld=%0d required 0/0", nm, both, hb);
        end
        n_cmp++;
        if (da !== 1'b0) begin
            n_err++; $display("FAIL %s done_width: done still %b required 0", nm, da);
        end
        exp_prev = exp;
    endtask

    task automatic test_directed;
        run_and_check("sra_neg",  2'b10, 5'd4,  32'h8000_0000, 1'b0);
        run_and_check("srl_msb",  2'b01, 5'd4,  32'h8000_0000, 1'b0);
        run_and_check("sll_31",   2'b00, 5'd31, 32'h0000_0001, 1'b0);
        for (int o = 0; o < 4; o++) run_and_check("shamt0", 2'(o), 5'd0, 32'h1234_5678, 1'b0);
        run_and_check("op11",     2'b11, 5'd1,  32'h0000_0001, 1'b0);
        n_cmp++;
`ifdef ITER_SHIFT_ROTATE_EN
        if (exp_prev !== 32'h8000_0000 || bus.shift_result !== 32'h8000_0000) begin
            n_err++; $display("FAIL op11_value: got %h required 80000000", bus.shift_result);
        end
`else
        if (exp_prev !== 32'h0 || bus.shift_result !== 32'h0) begin
            n_err++; $display("FAIL op11_value: got %h required 00000000", bus.shift_result);
        end
`endif
    endtask

    task automatic test_random_back_to_back;
        for (int i = 0; i < 40; i++)
            run_and_check("random", 2'($urandom), 5'($urandom), $urandom, bit'(i % 2));
    endtask

    task automatic test_ignore_mid_op;
        int pulses = 0, busy_after = 0;
        logic [31:0] res = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.shamt = 5'd8; bus.input_a = 32'hFFFF_FFFF;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c == 3) begin
                bus.start = 1'b1; bus.input_a = 32'h0; bus.shamt = 5'd1;
            end
            if (bus.done === 1'b1) begin
                pulses++; res = bus.shift_result;
            end else if (pulses > 0 && bus.busy === 1'b1) busy_after++;
        end
        bus.start = 1'b0;
        n_cmp++;
        if (pulses != 1) begin
            n_err++; $display("FAIL ignore_pulses: got %0d done pulses required 1", pulses);
        end
        n_cmp++;
        if (res !== 32'h00FF_FFFF) begin
            n_err++; $display("FAIL ignore_result: got %h required 00ffffff", res);
        end
        n_cmp++;
        if (busy_after != 0) begin
            n_err++; $display("FAIL ignore_restart: busy for %0d cycles after done required 0", busy_after);
        end
        exp_prev = 32'h00FF_FFFF;
    endtask

    task automatic test_reset_mid_op;
        int pulses = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.shamt = 5'd10; bus.input_a = 32'h0000_00F1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done} !== 2'b00 || bus.shift_result !== 32'h0) begin
            n_err++; $display("FAIL midreset_state: busy,done=%b result=%h required 00 / 00000000",
                              {bus.busy, bus.done}, bus.shift_result);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        reset_n = 1'b1;
        bus.start = 1'b1; bus.op = 2'b10; bus.shamt = 5'd3; bus.input_a = 32'h8000_0010;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_err++; $display("FAIL midreset_accept: busy=%b required 1 on first edge after release", bus.busy);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1 && bus.shift_result !== 32'hF000_0002) pulses += 100;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_err++; $display("FAIL midreset_pulses: stray/bad done events=%0d required 0", pulses);
        end
        n_cmp++;
        if (bus.shift_result !== 32'hF000_0002) begin
            n_err++; $display("FAIL midreset_restart: got %h required f0000002", bus.shift_result);
        end
        exp_prev = 32'hF000_0002;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_mid_op();
        test_reset_mid_op();
        test_random_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

endmodule
